// File: rtl/mem_port_arbiter.sv
// Shares one single-port data memory between instruction fetch and load/store.
// Data wins ties; a streak counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [2:0]  dm_funct3,
  input  logic [63:0] dm_addr,
  input  logic [63:0] dm_wdata,
  output logic        dm_rvalid,
  output logic [63:0] dm_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  mem_funct3,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [63:0] mem_rdata,
  output logic        busy
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state;
  logic [SW-1:0] streak;
  logic          owner_dm;
  logic          grant_dm;

  // Data wins unless fetch is waiting and the data streak has hit the limit.
  assign grant_dm = dm_req && (!if_req || (streak < LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      streak     <= '0;
      owner_dm   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_funct3 <= 3'b000;
      mem_addr   <= 64'h0;
      mem_wdata  <= 64'h0;
      if_rvalid  <= 1'b0;
      if_rdata   <= 32'h0;
      dm_rvalid  <= 1'b0;
      dm_rdata   <= 64'h0;
      busy       <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || dm_req) begin
            state   <= BUSY;
            busy    <= 1'b1;
            mem_req <= 1'b1;
            if (grant_dm) begin
              owner_dm   <= 1'b1;
              mem_we     <= dm_we;
              mem_funct3 <= dm_funct3;
              mem_addr   <= dm_addr;
              mem_wdata  <= dm_wdata;
              if (if_req && (streak != LIMIT)) begin
                streak <= streak + SW'(1);
              end
            end else begin
              // Fetches are always 32-bit unsigned reads (lwu).
              owner_dm   <= 1'b0;
              mem_we     <= 1'b0;
              mem_funct3 <= 3'b110;
              mem_addr   <= if_addr;
              mem_wdata  <= 64'h0;
              streak     <= '0;
            end
          end
        end
        BUSY: begin
          if (mem_ready) begin
            state   <= RESP;
            mem_req <= 1'b0;
            if (owner_dm) begin
              dm_rvalid <= 1'b1;
              dm_rdata  <= mem_we ? 64'h0 : mem_rdata;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata[31:0];
            end
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: memory model with programmable
// ready delay, scoreboard queue of expected responses, one task per scenario.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [2:0]  dm_funct3;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic        dm_rvalid;
  logic [63:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  mem_funct3;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ready;
  logic [63:0] mem_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        is_dm;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];

  logic [63:0] mem_model [logic [63:0]];
  int          ready_delay = 0;
  int          wait_cnt = 0;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_funct3  (dm_funct3),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_rvalid  (dm_rvalid),
    .dm_rdata   (dm_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_funct3 (mem_funct3),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model_read(input logic [63:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 64'hA5A5_0F0F_3C3C_9696;
  endfunction

  // Memory responds ready_delay cycles into each request; stores commit on ready.
  always @(negedge clk) begin
    if (mem_req) begin
      if (wait_cnt == ready_delay) begin
        mem_ready = 1'b1;
        if (mem_we) begin
          mem_model[mem_addr] = mem_wdata;
          mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        end else begin
          mem_rdata = model_read(mem_addr);
        end
      end else begin
        mem_ready = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ready = 1'b0;
      wait_cnt = 0;
    end
  end

  task automatic wait_rvalid(output int cycles, output bit ok);
    ok = 1'b0;
    cycles = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      cycles++;
      if (if_rvalid || dm_rvalid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req got %b want 0", mem_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid got %b%b want 00", if_rvalid, dm_rvalid); end
    checks++; if (mem_addr !== 64'h0 || mem_wdata !== 64'h0 || mem_funct3 !== 3'b0 || mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_payload got addr %h wdata %h f3 %b we %b want zeros", mem_addr, mem_wdata, mem_funct3, mem_we); end
    checks++; if (if_rdata !== 32'h0 || dm_rdata !== 64'h0) begin errors++; $display("[TB] FAIL reset_rdata got %h/%h want 0", if_rdata, dm_rdata); end
    checks++; if (int'(dut.streak) != 0) begin errors++; $display("[TB] FAIL reset_streak got %0d want 0", dut.streak); end
    rst = 1'b0;
  endtask

  task automatic test_single_fetch;
    int cyc;
    bit ok;
    exp_t e;
    mem_model[64'h40] = 64'hDEAD_BEEF_0000_0013;
    @(negedge clk);
    ready_delay = 0;
    if_addr = 64'h40;
    if_req = 1'b1;
    sb.push_back({1'b0, 64'h0000_0000_0000_0013});
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL fetch_issue got req %b busy %b want 1 1", mem_req, busy); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL fetch_we got %b want 0", mem_we); end
    checks++; if (mem_funct3 !== 3'b110) begin errors++; $display("[TB] FAIL fetch_funct3 got %b want 110", mem_funct3); end
    checks++; if (mem_addr !== 64'h40) begin errors++; $display("[TB] FAIL fetch_addr got %h want 40", mem_addr); end
    wait_rvalid(cyc, ok);
    checks++;
    if (!ok) begin
      errors++; $display("[TB] FAIL fetch_timeout got no rvalid want rvalid");
    end else begin
      if (cyc + 1 != 2) begin errors++; $display("[TB] FAIL fetch_latency got %0d want 2", cyc + 1); end
      e = sb.pop_front();
      checks++; if (if_rvalid !== 1'b1 || dm_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL fetch_owner got if %b dm %b want if", if_rvalid, dm_rvalid); end
      checks++; if (if_rdata !== e.data[31:0]) begin errors++; $display("[TB] FAIL fetch_rdata got %h want %h", if_rdata, e.data[31:0]); end
    end
    if_req = 1'b0;
    @(negedge clk);
    checks++; if (if_rvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL fetch_strobe_len got rvalid %b busy %b want 0 0", if_rvalid, busy); end
  endtask

  task automatic test_store_load;
    int busy_cycles;
    bit got;
    int cyc;
    bit ok;
    exp_t e;
    @(negedge clk);
    ready_delay = 3;
    dm_we = 1'b1;
    dm_funct3 = 3'b011;
    dm_addr = 64'h700;
    dm_wdata = 64'h1122_3344_5566_7788;
    dm_req = 1'b1;
    sb.push_back({1'b1, 64'h0});
    busy_cycles = 0;
    got = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (mem_req) begin
        busy_cycles++;
        checks++; if (mem_we !== 1'b1) begin errors++; $display("[TB] FAIL store_we got %b want 1", mem_we); end
      end
      if (dm_rvalid) begin
        got = 1'b1;
        e = sb.pop_front();
        checks++; if (dm_rdata !== e.data) begin errors++; $display("[TB] FAIL store_rdata got %h want %h", dm_rdata, e.data); end
        dm_req = 1'b0;
        break;
      end
    end
    checks++; if (!got || busy_cycles != 4) begin errors++; $display("[TB] FAIL store_busy_cycles got %0d (rvalid %b) want 4", busy_cycles, got); end
    @(negedge clk);
    ready_delay = 1;
    dm_we = 1'b0;
    dm_req = 1'b1;
    sb.push_back({1'b1, 64'h1122_3344_5566_7788});
    wait_rvalid(cyc, ok);
    checks++;
    if (!ok || dm_rvalid !== 1'b1) begin
      errors++; $display("[TB] FAIL load_timeout got dm_rvalid %b want 1", dm_rvalid);
    end else begin
      e = sb.pop_front();
      checks++; if (dm_rdata !== e.data) begin errors++; $display("[TB] FAIL load_rdata got %h want %h", dm_rdata, e.data); end
    end
    dm_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tie_break;
    int cyc;
    bit ok;
    exp_t e;
    logic [63:0] f;
    int exp_streak;
    @(negedge clk);
    ready_delay = 0;
    if_addr = 64'h80;
    dm_we = 1'b0;
    dm_funct3 = 3'b011;
    dm_addr = 64'h88;
    f = model_read(64'h80);
    sb.push_back({1'b1, model_read(64'h88)});
    sb.push_back({1'b0, 32'h0, f[31:0]});
    if_req = 1'b1;
    dm_req = 1'b1;
    exp_streak = 0;
    for (int n = 0; n < 2; n++) begin
      wait_rvalid(cyc, ok);
      checks++;
      if (!ok) begin
        errors++; $display("[TB] FAIL tie_timeout got no rvalid want rvalid %0d", n);
        break;
      end
      e = sb.pop_front();
      exp_streak = e.is_dm ? exp_streak + 1 : 0;
      if (dm_rvalid !== e.is_dm || if_rvalid !== !e.is_dm) begin
        errors++; $display("[TB] FAIL tie_order got if %b dm %b want dm=%b", if_rvalid, dm_rvalid, e.is_dm);
      end
      checks++;
      if ((e.is_dm ? dm_rdata : {32'h0, if_rdata}) !== e.data) begin
        errors++; $display("[TB] FAIL tie_data got %h/%h want %h", dm_rdata, if_rdata, e.data);
      end
      checks++; if (int'(dut.streak) != exp_streak) begin errors++; $display("[TB] FAIL tie_streak got %0d want %0d", dut.streak, exp_streak); end
      if (dm_rvalid) dm_req = 1'b0;
      if (if_rvalid) if_req = 1'b0;
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_starvation;
    int cyc;
    bit ok;
    exp_t e;
    logic [63:0] f;
    int exp_streak;
    bit if_waiting;
    @(negedge clk);
    ready_delay = 0;
    if_addr = 64'h200;
    dm_we = 1'b0;
    dm_funct3 = 3'b011;
    dm_addr = 64'h208;
    f = model_read(64'h200);
    for (int k = 0; k < 4; k++) sb.push_back({1'b1, model_read(64'h208)});
    sb.push_back({1'b0, 32'h0, f[31:0]});
    sb.push_back({1'b1, model_read(64'h208)});
    if_req = 1'b1;
    dm_req = 1'b1;
    exp_streak = 0;
    if_waiting = 1'b1;
    for (int n = 0; n < 6; n++) begin
      wait_rvalid(cyc, ok);
      checks++;
      if (!ok) begin
        errors++; $display("[TB] FAIL starve_timeout got no rvalid want grant %0d", n);
        break;
      end
      e = sb.pop_front();
      if (e.is_dm) begin
        if (if_waiting && exp_streak < 4) exp_streak++;
      end else begin
        exp_streak = 0;
      end
      if (dm_rvalid !== e.is_dm || if_rvalid !== !e.is_dm) begin
        errors++; $display("[TB] FAIL starve_order grant %0d got if %b dm %b want dm=%b", n, if_rvalid, dm_rvalid, e.is_dm);
      end
      checks++; if (int'(dut.streak) != exp_streak) begin errors++; $display("[TB] FAIL starve_streak grant %0d got %0d want %0d", n, dut.streak, exp_streak); end
      if (if_rvalid) begin
        if_req = 1'b0;
        if_waiting = 1'b0;
      end
      if (dm_rvalid) begin
        dm_req = 1'b0;
        if (n < 5) begin
          @(negedge clk);
          dm_req = 1'b1;
        end
      end
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_payload_change;
    int rv_count;
    exp_t e;
    @(negedge clk);
    ready_delay = 2;
    dm_we = 1'b0;
    dm_funct3 = 3'b010;
    dm_addr = 64'h300;
    dm_req = 1'b1;
    sb.push_back({1'b1, model_read(64'h300)});
    rv_count = 0;
    @(negedge clk);
    dm_addr = 64'h0;
    for (int c = 0; c < 12; c++) begin
      if (mem_req) begin
        checks++; if (mem_addr !== 64'h300) begin errors++; $display("[TB] FAIL payload_addr got %h want 300", mem_addr); end
      end
      if (dm_rvalid) begin
        rv_count++;
        dm_req = 1'b0;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checks++; if (dm_rdata !== e.data) begin errors++; $display("[TB] FAIL payload_rdata got %h want %h", dm_rdata, e.data); end
        end
      end
      @(negedge clk);
    end
    checks++; if (rv_count != 1) begin errors++; $display("[TB] FAIL payload_strobes got %0d want 1", rv_count); end
    dm_req = 1'b0;
  endtask

  task automatic test_reset_mid_busy;
    int cyc;
    bit ok;
    exp_t e;
    logic [63:0] f;
    @(negedge clk);
    ready_delay = 10;
    if_addr = 64'h100;
    if_req = 1'b1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_issue got %b want 1", mem_req); end
    #2 rst = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_mem_req got %b want 0", mem_req); end
    checks++; if (busy !== 1'b0 || if_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_state got busy %b rvalid %b want 0 0", busy, if_rvalid); end
    @(negedge clk);
    rst = 1'b0;
    ready_delay = 0;
    f = model_read(64'h100);
    sb.push_back({1'b0, 32'h0, f[31:0]});
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h100) begin errors++; $display("[TB] FAIL rstmid_reissue got req %b addr %h want 1 100", mem_req, mem_addr); end
    wait_rvalid(cyc, ok);
    checks++;
    if (!ok || if_rvalid !== 1'b1) begin
      errors++; $display("[TB] FAIL rstmid_timeout got if_rvalid %b want 1", if_rvalid);
    end else begin
      e = sb.pop_front();
      checks++; if (if_rdata !== e.data[31:0]) begin errors++; $display("[TB] FAIL rstmid_rdata got %h want %h", if_rdata, e.data[31:0]); end
    end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0;
    if_addr = 64'h0;
    dm_req = 1'b0;
    dm_we = 1'b0;
    dm_funct3 = 3'b0;
    dm_addr = 64'h0;
    dm_wdata = 64'h0;
    mem_ready = 1'b0;
    mem_rdata = 64'h0;
    test_reset();
    test_single_fetch();
    test_store_load();
    test_tie_break();
    test_starvation();
    test_payload_change();
    test_reset_mid_busy();
    checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL scoreboard_leftover got %0d want 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
